// File: rtl/dsp_pkg.sv
// ---------------------------------------------------------------------------
// dsp_pkg
//   Shared types for the frequency-sweep sequencer.
//   - DEFAULT_FREQ_WIDTH : default width of NCO phase-increment words
//   - sweep_mode_e       : sweep mode encoding as seen on the `mode` input
//   - sweep_state_e      : sequencer state encoding
// ---------------------------------------------------------------------------
package dsp_pkg;

    localparam int DEFAULT_FREQ_WIDTH = 32;

    typedef enum logic [1:0] {
        SWEEP_SINGLE   = 2'd0,
        SWEEP_REPEAT   = 2'd1,
        SWEEP_TRIANGLE = 2'd2,
        SWEEP_RSVD     = 2'd3   // decoded exactly like SWEEP_SINGLE
    } sweep_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sweep_state_e;

endpackage

// File: rtl/sweep_step_clamp.sv
// ---------------------------------------------------------------------------
// sweep_step_clamp
//   Combinational +/- step with clamp to target.
//   Ports:
//     cur    in  current increment value
//     step   in  unsigned step magnitude (0 means jump straight to target)
//     target in  value the sweep is heading towards
//     up     in  1 = add step, 0 = subtract step
//     next   out next increment value, never beyond target, never wrapped
// ---------------------------------------------------------------------------
module sweep_step_clamp #(
    parameter int FREQ_WIDTH = 32
) (
    input  logic [FREQ_WIDTH-1:0] cur,
    input  logic [FREQ_WIDTH-1:0] step,
    input  logic [FREQ_WIDTH-1:0] target,
    input  logic                  up,
    output logic [FREQ_WIDTH-1:0] next
);

    logic [FREQ_WIDTH:0] sum_ext;
    logic [FREQ_WIDTH:0] diff_ext;
    logic                passed;

    always_comb begin
        // One extra bit catches wrap past all-ones (carry) or below zero (borrow).
        sum_ext  = {1'b0, cur} + {1'b0, step};
        diff_ext = {1'b0, cur} - {1'b0, step};

        if (up) begin
            passed = sum_ext[FREQ_WIDTH] || (sum_ext[FREQ_WIDTH-1:0] > target);
        end else begin
            passed = diff_ext[FREQ_WIDTH] || (diff_ext[FREQ_WIDTH-1:0] < target);
        end

        if ((step == '0) || passed) begin
            next = target;
        end else if (up) begin
            next = sum_ext[FREQ_WIDTH-1:0];
        end else begin
            next = diff_ext[FREQ_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/nco_freq_sweep.sv
// ---------------------------------------------------------------------------
// nco_freq_sweep
//   Drives an NCO phase-increment port with linear/stepped frequency sweeps
//   in single-shot, repeating (sawtooth) or triangle mode.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     start          pulse: latch configuration and (re)start a sweep
//     stop           pulse: abort a running sweep (wins over start)
//     mode           0 single, 1 repeat, 2 triangle, 3 as single
//     f_start/f_stop sweep end points (either order)
//     f_step         unsigned step magnitude
//     dwell          cycles per value, 0 treated as 1
//     freq_out       registered increment for the NCO
//     sweep_active   high while running
//     step_strobe    pulse with every stepped change of freq_out
//     sweep_done     pulse when a single-mode sweep finishes
// ---------------------------------------------------------------------------
module nco_freq_sweep
    import dsp_pkg::*;
#(
    parameter int FREQ_WIDTH  = DEFAULT_FREQ_WIDTH,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [1:0]             mode,
    input  logic [FREQ_WIDTH-1:0]  f_start,
    input  logic [FREQ_WIDTH-1:0]  f_stop,
    input  logic [FREQ_WIDTH-1:0]  f_step,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic [FREQ_WIDTH-1:0]  freq_out,
    output logic                   sweep_active,
    output logic                   step_strobe,
    output logic                   sweep_done
);

    sweep_state_e           state_q,    state_d;
    sweep_mode_e            mode_q,     mode_d;
    logic [FREQ_WIDTH-1:0]  f_start_q,  f_start_d;
    logic [FREQ_WIDTH-1:0]  f_stop_q,   f_stop_d;
    logic [FREQ_WIDTH-1:0]  f_step_q,   f_step_d;
    logic [DWELL_WIDTH-1:0] reload_q,   reload_d;
    logic [DWELL_WIDTH-1:0] cnt_q,      cnt_d;
    logic                   dir_up_q,   dir_up_d;
    logic                   fwd_q,      fwd_d;
    logic [FREQ_WIDTH-1:0]  freq_q,     freq_d;
    logic                   active_q,   active_d;
    logic                   strobe_q,   strobe_d;
    logic                   done_q,     done_d;

    logic [FREQ_WIDTH-1:0]  cur_target;
    logic                   at_target;
    logic                   tri_turn;
    logic                   clamp_fwd;
    logic [FREQ_WIDTH-1:0]  clamp_target;
    logic                   clamp_up;
    logic [FREQ_WIDTH-1:0]  clamp_next;
    logic [DWELL_WIDTH-1:0] dwell_load;

    // fwd_q: heading to f_stop (1) or back to f_start (0, triangle only).
    assign cur_target = fwd_q ? f_stop_q : f_start_q;
    assign at_target  = (freq_q == cur_target);

    // Triangle reversal steps one step off the endpoint toward the other end.
    assign tri_turn     = (mode_q == SWEEP_TRIANGLE) && at_target;
    assign clamp_fwd    = tri_turn ? ~fwd_q : fwd_q;
    assign clamp_target = clamp_fwd ? f_stop_q : f_start_q;
    assign clamp_up     = clamp_fwd ? dir_up_q : ~dir_up_q;

    // Counter runs dwell-1 .. 0, so a value is held exactly max(dwell,1) cycles.
    assign dwell_load = (dwell == '0) ? '0 : (dwell - DWELL_WIDTH'(1));

    sweep_step_clamp #(
        .FREQ_WIDTH (FREQ_WIDTH)
    ) u_step_clamp (
        .cur    (freq_q),
        .step   (f_step_q),
        .target (clamp_target),
        .up     (clamp_up),
        .next   (clamp_next)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        f_start_d = f_start_q;
        f_stop_d  = f_stop_q;
        f_step_d  = f_step_q;
        reload_d  = reload_q;
        cnt_d     = cnt_q;
        dir_up_d  = dir_up_q;
        fwd_d     = fwd_q;
        freq_d    = freq_q;
        active_d  = active_q;
        strobe_d  = 1'b0;
        done_d    = 1'b0;

        if (stop) begin
            // Abort freezes freq_out; also masks a coincident start.
            state_d  = ST_IDLE;
            active_d = 1'b0;
        end else if (start) begin
            mode_d    = sweep_mode_e'(mode);
            f_start_d = f_start;
            f_stop_d  = f_stop;
            f_step_d  = f_step;
            reload_d  = dwell_load;
            cnt_d     = dwell_load;
            dir_up_d  = (f_stop >= f_start);
            fwd_d     = 1'b1;
            freq_d    = f_start;
            active_d  = 1'b1;
            state_d   = ST_RUN;
        end else if (state_q == ST_RUN) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - DWELL_WIDTH'(1);
            end else begin
                cnt_d = reload_q;
                if (!at_target) begin
                    freq_d   = clamp_next;
                    strobe_d = 1'b1;
                end else begin
                    case (mode_q)
                        SWEEP_REPEAT: begin
                            freq_d   = f_start_q;
                            strobe_d = 1'b1;
                        end
                        SWEEP_TRIANGLE: begin
                            fwd_d    = ~fwd_q;
                            freq_d   = clamp_next;
                            strobe_d = 1'b1;
                        end
                        default: begin
                            state_d  = ST_IDLE;
                            active_d = 1'b0;
                            done_d   = 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= SWEEP_SINGLE;
            f_start_q <= '0;
            f_stop_q  <= '0;
            f_step_q  <= '0;
            reload_q  <= '0;
            cnt_q     <= '0;
            dir_up_q  <= 1'b1;
            fwd_q     <= 1'b1;
            freq_q    <= '0;
            active_q  <= 1'b0;
            strobe_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            f_start_q <= f_start_d;
            f_stop_q  <= f_stop_d;
            f_step_q  <= f_step_d;
            reload_q  <= reload_d;
            cnt_q     <= cnt_d;
            dir_up_q  <= dir_up_d;
            fwd_q     <= fwd_d;
            freq_q    <= freq_d;
            active_q  <= active_d;
            strobe_q  <= strobe_d;
            done_q    <= done_d;
        end
    end

    assign freq_out     = freq_q;
    assign sweep_active = active_q;
    assign step_strobe  = strobe_q;
    assign sweep_done   = done_q;

endmodule

// File: tb/tb_nco_freq_sweep.sv
// ---------------------------------------------------------------------------
// tb_nco_freq_sweep
//   Directed scoreboard bench for nco_freq_sweep. Each stimulus cycle queues
//   the hand-computed outputs expected after the next rising edge; a monitor
//   pops and compares them independently.
// ---------------------------------------------------------------------------
module tb_nco_freq_sweep;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [31:0] f_start;
    logic [31:0] f_stop;
    logic [31:0] f_step;
    logic [15:0] dwell;
    logic [31:0] freq_out;
    logic        sweep_active;
    logic        step_strobe;
    logic        sweep_done;

    typedef struct packed {
        logic [31:0] f;
        logic        a;
        logic        s;
        logic        d;
        logic [15:0] id;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] vec_id   = 16'd0;

    nco_freq_sweep #(
        .FREQ_WIDTH  (32),
        .DWELL_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .mode         (mode),
        .f_start      (f_start),
        .f_stop       (f_stop),
        .f_step       (f_step),
        .dwell        (dwell),
        .freq_out     (freq_out),
        .sweep_active (sweep_active),
        .step_strobe  (step_strobe),
        .sweep_done   (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push(input logic [31:0] f, input logic a, input logic s, input logic d);
        exp_q.push_back('{f: f, a: a, s: s, d: d, id: vec_id});
        vec_id = vec_id + 16'd1;
    endfunction

    // Plain cycle: no start, no stop.
    task automatic idle(input logic [31:0] f, input logic a, input logic s, input logic d);
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        push(f, a, s, d);
    endtask

    // Stop pulse.
    task automatic halt(input logic [31:0] f, input logic a, input logic s, input logic d);
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b1;
        push(f, a, s, d);
    endtask

    // Start pulse with configuration (optionally with stop in the same cycle).
    task automatic go(input logic [1:0] m, input logic [31:0] fs, input logic [31:0] fe,
                      input logic [31:0] fst, input logic [15:0] dw, input logic sp,
                      input logic [31:0] f, input logic a, input logic s, input logic d);
        @(negedge clk);
        mode    = m;
        f_start = fs;
        f_stop  = fe;
        f_step  = fst;
        dwell   = dw;
        start   = 1'b1;
        stop    = sp;
        push(f, a, s, d);
    endtask

    // Monitor: outputs are registered and do not use a valid, so every
    // sampled cycle with a queued expectation is an output to compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({freq_out, sweep_active, step_strobe, sweep_done} !== {e.f, e.a, e.s, e.d}) begin
                    n_fail++;
                    $display("FAIL vec%0d: got freq_out=%h active=%b strobe=%b done=%b, want freq_out=%h active=%b strobe=%b done=%b",
                             e.id, freq_out, sweep_active, step_strobe, sweep_done, e.f, e.a, e.s, e.d);
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        mode    = 2'd0;
        f_start = 32'd0;
        f_stop  = 32'd0;
        f_step  = 32'd0;
        dwell   = 16'd0;

        // Reset state
        idle(32'd0, 1'b0, 1'b0, 1'b0);
        idle(32'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(32'd0, 1'b0, 1'b0, 1'b0);
        halt(32'd0, 1'b0, 1'b0, 1'b0);   // stop in IDLE does nothing

        // Single up 100->130 step 10 dwell 2; config churn during RUN ignored
        go(2'd0, 32'd100, 32'd130, 32'd10, 16'd2, 1'b0, 32'd100, 1'b1, 1'b0, 1'b0);
        idle(32'd100, 1'b1, 1'b0, 1'b0);
        mode = 2'd2; f_start = 32'd0; f_stop = 32'd0; f_step = 32'd1; dwell = 16'd7;
        idle(32'd110, 1'b1, 1'b1, 1'b0);
        idle(32'd110, 1'b1, 1'b0, 1'b0);
        idle(32'd120, 1'b1, 1'b1, 1'b0);
        idle(32'd120, 1'b1, 1'b0, 1'b0);
        idle(32'd130, 1'b1, 1'b1, 1'b0);
        idle(32'd130, 1'b1, 1'b0, 1'b0);
        idle(32'd130, 1'b0, 1'b0, 1'b1);
        idle(32'd130, 1'b0, 1'b0, 1'b0);

        // Down sweep with overshoot clamp 125->100 step 10
        go(2'd0, 32'd125, 32'd100, 32'd10, 16'd1, 1'b0, 32'd125, 1'b1, 1'b0, 1'b0);
        idle(32'd115, 1'b1, 1'b1, 1'b0);
        idle(32'd105, 1'b1, 1'b1, 1'b0);
        idle(32'd100, 1'b1, 1'b1, 1'b0);
        idle(32'd100, 1'b0, 1'b0, 1'b1);
        idle(32'd100, 1'b0, 1'b0, 1'b0);

        // Up sweep with overshoot clamp 100->125 step 10
        go(2'd0, 32'd100, 32'd125, 32'd10, 16'd1, 1'b0, 32'd100, 1'b1, 1'b0, 1'b0);
        idle(32'd110, 1'b1, 1'b1, 1'b0);
        idle(32'd120, 1'b1, 1'b1, 1'b0);
        idle(32'd125, 1'b1, 1'b1, 1'b0);
        idle(32'd125, 1'b0, 1'b0, 1'b1);

        // 32-bit wrap clamp
        go(2'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd1, 1'b0, 32'hFFFF_FF00, 1'b1, 1'b0, 1'b0);
        idle(32'hFFFF_FF80, 1'b1, 1'b1, 1'b0);
        idle(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        idle(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        idle(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // Triangle 10<->30, stop at second 20
        go(2'd2, 32'd10, 32'd30, 32'd10, 16'd1, 1'b0, 32'd10, 1'b1, 1'b0, 1'b0);
        idle(32'd20, 1'b1, 1'b1, 1'b0);
        idle(32'd30, 1'b1, 1'b1, 1'b0);
        idle(32'd20, 1'b1, 1'b1, 1'b0);
        halt(32'd20, 1'b0, 1'b0, 1'b0);
        idle(32'd20, 1'b0, 1'b0, 1'b0);
        idle(32'd20, 1'b0, 1'b0, 1'b0);

        // Longer triangle run, stopped at 30
        go(2'd2, 32'd10, 32'd30, 32'd10, 16'd1, 1'b0, 32'd10, 1'b1, 1'b0, 1'b0);
        idle(32'd20, 1'b1, 1'b1, 1'b0);
        idle(32'd30, 1'b1, 1'b1, 1'b0);
        idle(32'd20, 1'b1, 1'b1, 1'b0);
        idle(32'd10, 1'b1, 1'b1, 1'b0);
        idle(32'd20, 1'b1, 1'b1, 1'b0);
        idle(32'd30, 1'b1, 1'b1, 1'b0);
        halt(32'd30, 1'b0, 1'b0, 1'b0);

        // Repeat 0->20 step 10, dwell 0 acts as 1
        go(2'd1, 32'd0, 32'd20, 32'd10, 16'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(32'd10, 1'b1, 1'b1, 1'b0);
        idle(32'd20, 1'b1, 1'b1, 1'b0);
        idle(32'd0,  1'b1, 1'b1, 1'b0);
        idle(32'd10, 1'b1, 1'b1, 1'b0);
        idle(32'd20, 1'b1, 1'b1, 1'b0);
        idle(32'd0,  1'b1, 1'b1, 1'b0);

        // Start during RUN restarts with new config
        go(2'd0, 32'd50, 32'd60, 32'd10, 16'd1, 1'b0, 32'd50, 1'b1, 1'b0, 1'b0);
        idle(32'd60, 1'b1, 1'b1, 1'b0);
        idle(32'd60, 1'b0, 1'b0, 1'b1);

        // Start and stop together: stays IDLE
        go(2'd0, 32'd5, 32'd9, 32'd1, 16'd1, 1'b1, 32'd60, 1'b0, 1'b0, 1'b0);
        idle(32'd60, 1'b0, 1'b0, 1'b0);

        // Step 0 single: f_start dwell, f_stop dwell, done
        go(2'd0, 32'd7, 32'd40, 32'd0, 16'd2, 1'b0, 32'd7, 1'b1, 1'b0, 1'b0);
        idle(32'd7,  1'b1, 1'b0, 1'b0);
        idle(32'd40, 1'b1, 1'b1, 1'b0);
        idle(32'd40, 1'b1, 1'b0, 1'b0);
        idle(32'd40, 1'b0, 1'b0, 1'b1);

        // Equal endpoints, single: one dwell then done
        go(2'd0, 32'd33, 32'd33, 32'd5, 16'd1, 1'b0, 32'd33, 1'b1, 1'b0, 1'b0);
        idle(32'd33, 1'b0, 1'b0, 1'b1);

        // Equal endpoints, repeat: hold with a strobe every dwell
        go(2'd1, 32'd44, 32'd44, 32'd5, 16'd1, 1'b0, 32'd44, 1'b1, 1'b0, 1'b0);
        idle(32'd44, 1'b1, 1'b1, 1'b0);
        idle(32'd44, 1'b1, 1'b1, 1'b0);
        halt(32'd44, 1'b0, 1'b0, 1'b0);

        // Reserved mode behaves as single
        go(2'd3, 32'd1, 32'd3, 32'd2, 16'd1, 1'b0, 32'd1, 1'b1, 1'b0, 1'b0);
        idle(32'd3, 1'b1, 1'b1, 1'b0);
        idle(32'd3, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-sweep
        go(2'd1, 32'd0, 32'd20, 32'd10, 16'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(32'd10, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        push(32'd0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({freq_out, sweep_active, step_strobe, sweep_done} !== {32'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got freq_out=%h active=%b strobe=%b done=%b, want all zero",
                     freq_out, sweep_active, step_strobe, sweep_done);
        end
        idle(32'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(32'd0, 1'b0, 1'b0, 1'b0);
        idle(32'd0, 1'b0, 1'b0, 1'b0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nco_freq_sweep.md
Name: nco_freq_sweep

Overview:
- Sequencer that drives the NCO `freq_in` phase-increment port directly, so the NCO produces linear chirps and stepped sweeps without a processor in the loop.
- Latches a sweep configuration on `start`, then walks the output increment from `f_start` toward `f_stop` in `f_step` increments.
- Holds each value for a programmable dwell.
- Supports single-shot, repeating (sawtooth) and triangle (up/down) modes.

Parameters:
- FREQ_WIDTH, 32, width of phase increment words; matches NCO `freq_in`.
- DWELL_WIDTH, 16, width of dwell counter / dwell input.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latch config and begin sweep.
- stop  in  1  one-cycle pulse; abort sweep.
- mode  in  2  0=single, 1=repeat (sawtooth), 2=triangle, 3=reserved, behaves as single.
- f_start  in  FREQ_WIDTH  first increment value.
- f_stop  in  FREQ_WIDTH  end increment value; may be above or below `f_start`.
- f_step  in  FREQ_WIDTH  unsigned step magnitude.
- dwell  in  DWELL_WIDTH  cycles each value is held; 0 treated as 1.
- freq_out  out  FREQ_WIDTH  registered increment; connects to NCO `freq_in`.
- sweep_active  out  1  high while a sweep is running.
- step_strobe  out  1  one-cycle pulse on every `freq_out` change made by a step, including wrap and reversal.
- sweep_done  out  1  one-cycle pulse when a single-mode sweep completes.

Behaviour:
- Reset (async, `rst_n`=0): state IDLE; `freq_out`=0; `sweep_active`=0; `step_strobe`=0; `sweep_done`=0. All outputs are registered.

State machine: IDLE, RUN.
- IDLE: `start`=1 latches `mode`, `f_start`, `f_stop`, `f_step`, `dwell`, and direction `dir_up`=(`f_stop` >= `f_start`). Next cycle: `freq_out`=`f_start`, `sweep_active`=1, dwell counter loaded, state RUN.
- RUN: each value is held exactly max(`dwell`,1) cycles. At the end of a dwell:
  - Target not yet reached: next = `freq_out` ± `f_step`. The result is clamped to the current target if it passes it. Overshoot and 32-bit wrap are detected with a FREQ_WIDTH+1 add/sub (carry/borrow = passed). `step_strobe`=1 for one cycle.
  - Reached `f_stop`, mode single/reserved: next cycle returns to IDLE, `sweep_active`=0, `sweep_done`=1 for one cycle, `freq_out` holds `f_stop`.
  - Reached `f_stop`, mode repeat: `freq_out`=`f_start`, `step_strobe`=1, continue.
  - Mode triangle: target toggles between `f_stop` and `f_start`; the reversal step moves one step off the endpoint. Each endpoint is held a single dwell. Runs until `stop`.
- `f_step`=0: treated as an immediate clamp to the target.
  - single: `f_start` dwell, then `f_stop` dwell, then done.
- `f_start`==`f_stop`: one dwell at that value, then done (single); repeat/triangle hold the value indefinitely, with a strobe every dwell.
- `stop` in RUN: next cycle IDLE, `sweep_active`=0, `freq_out` frozen at its current value, no `sweep_done`.
- `stop` in IDLE: no effect.
- `start` in RUN: restarts with the newly latched config, identical to a start from IDLE.
- Simultaneous `start` and `stop`: `stop` wins; the block goes to IDLE.
- Config inputs are sampled only at `start`; changes during RUN are ignored.
- Latency: `start` to first `f_start` on `freq_out`: 1 cycle. Step decision to new `freq_out`: registered, no extra bubble. Dwell timing is exact.

Decomposition:
- Shared package `dsp_pkg`: sweep mode enum (`SWEEP_SINGLE`, `SWEEP_REPEAT`, `SWEEP_TRIANGLE`), default FREQ_WIDTH.
- One natural sub-module: `sweep_step_clamp`, a combinational ±step with overshoot/wrap clamp to target. Instantiated once.

Test Plan:
- Single up: `f_start`=100, `f_stop`=130, `f_step`=10, `dwell`=2 -> `freq_out` 100,100,110,110,120,120,130,130.
  - `sweep_done` pulses the next cycle; `sweep_active` falls with it; `step_strobe` fires 3 times.
- Overshoot clamp, down sweep: 125→100, step 10, `dwell`=1 -> 125,115,105,100, then done. Then 100→125, step 10 -> 100,110,120,125.
- Wrap clamp: `f_start`=0xFFFFFF00, `f_stop`=0xFFFFFFFF, `f_step`=0x80, `dwell`=1 -> 0xFFFFFF00, 0xFFFFFF80, 0xFFFFFFFF; never 0x0.
- Triangle: 10→30, step 10, `dwell`=1 -> 10,20,30,20,10,20,30…; `stop` at the second 20 -> `freq_out` stays 20, `sweep_active`=0, no done.
- Repeat plus edge cases: 0→20 step 10 `dwell`=0 (acts as 1) -> 0,10,20,0,10…
  - `start`+`stop` same cycle -> stays IDLE.
  - `rst_n` low mid-sweep -> all outputs 0 asynchronously.
